// File: rtl/video_timing_gen_if.sv
// Scan-out timing bundle: run request in; pixel strobes, position, syncs out.
// frame_cnt exists only when VIDEO_TIMING_FRAME_CNT_EN is defined.
interface video_timing_gen_if #(
  parameter int CW = 10
);
  logic          run;
  logic          en_pix;
  logic [CW-1:0] x_pos;
  logic [CW-1:0] y_pos;
  logic          blank;
  logic          line_start;
  logic          frame_start;
  logic          h_sync;
  logic          v_sync;
  logic          active;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;

  modport master (
    input  run,
    output en_pix, x_pos, y_pos, blank, line_start,
    output frame_start, h_sync, v_sync, active, frame_cnt
  );
  modport slave (
    output run,
    input  en_pix, x_pos, y_pos, blank, line_start,
    input  frame_start, h_sync, v_sync, active, frame_cnt
  );
`else
  modport master (
    input  run,
    output en_pix, x_pos, y_pos, blank, line_start,
    output frame_start, h_sync, v_sync, active
  );
  modport slave (
    output run,
    input  en_pix, x_pos, y_pos, blank, line_start,
    input  frame_start, h_sync, v_sync, active
  );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised VESA-style timing generator with run/stop scan-out FSM.
// Optional 16-bit frame counter enabled by VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int SYNC_DELAY = 13,
  parameter int CW         = 10
) (
  input logic                clk,
  input logic                reset,
  video_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic H_ON = (H_POL != 0);
  localparam logic V_ON = (V_POL != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          en_pix_q, en_pix_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          adv, wrap_x, wrap_f;
  logic          h_raw, v_raw;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    en_pix_d  = (div_cnt_d == DIV_LAST);
  end

  assign wrap_x = (x_q == H_LAST);
  assign wrap_f = wrap_x && (y_q == V_LAST);

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    if (en_pix_q) begin
      unique case (state_q)
        IDLE: begin
          if (vif.run) state_d = RUN;
        end
        RUN: begin
          adv = 1'b1;
          if (!vif.run) state_d = STOPPING;
        end
        STOPPING: begin
          adv = 1'b1;
          if (vif.run) state_d = RUN;
          else if (wrap_f) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Entry from IDLE leaves x=y=0, so it also raises the pulses.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv) begin
      x_d = wrap_x ? '0 : x_q + 1'b1;
      if (wrap_x) y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
    line_start_d  = en_pix_q && (state_d != IDLE) && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  always_comb begin
    h_raw = ~H_ON;
    v_raw = ~V_ON;
    if (state_q != IDLE) begin
      if (x_q >= HS0 && x_q < HS1) h_raw = H_ON;
      if (y_q >= VS0 && y_q < VS1) v_raw = V_ON;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      en_pix_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      en_pix_q      <= en_pix_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_direct
      assign vif.h_sync = h_raw;
      assign vif.v_sync = v_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] h_sr_q, h_sr_d;
      logic [SYNC_DELAY-1:0] v_sr_q, v_sr_d;

      always_comb begin
        h_sr_d = (h_sr_q << 1) | SYNC_DELAY'(h_raw);
        v_sr_d = (v_sr_q << 1) | SYNC_DELAY'(v_raw);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          h_sr_q <= {SYNC_DELAY{~H_ON}};
          v_sr_q <= {SYNC_DELAY{~V_ON}};
        end else begin
          h_sr_q <= h_sr_d;
          v_sr_q <= v_sr_d;
        end
      end

      assign vif.h_sync = h_sr_q[SYNC_DELAY-1];
      assign vif.v_sync = v_sr_q[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif

  assign vif.en_pix      = en_pix_q;
  assign vif.x_pos       = x_q;
  assign vif.y_pos       = y_q;
  assign vif.blank       = (state_q == IDLE) || (x_q >= HA) || (y_q >= VA);
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.active      = (state_q != IDLE);
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 15x10 raster.
// Reference model tracks a linear pixel index per frame.
module tb_video_timing_gen;
  localparam int CLK_DIV    = 2;
  localparam int H_ACTIVE   = 8;
  localparam int H_FP       = 2;
  localparam int H_SYNC     = 3;
  localparam int H_BP       = 2;
  localparam int V_ACTIVE   = 6;
  localparam int V_FP       = 1;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 1;
  localparam int H_POL      = 0;
  localparam int V_POL      = 1;
  localparam int SYNC_DELAY = 3;
  localparam int CW         = 6;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE_CLKS  = HT * CLK_DIV;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;
  localparam bit H_ON = (H_POL != 0);
  localparam bit V_ON = (V_POL != 0);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  video_timing_gen_if #(.CW(CW)) vif ();
  video_timing_gen_if #(.CW(CW)) vif1 ();

  video_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .H_SYNC(H_SYNC), .H_BP(H_BP), .V_ACTIVE(V_ACTIVE),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL),
    .SYNC_DELAY(SYNC_DELAY), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .vif(vif.master)
  );

  video_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .H_SYNC(H_SYNC), .H_BP(H_BP), .V_ACTIVE(V_ACTIVE),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL),
    .SYNC_DELAY(0), .CW(CW)
  ) dut1 (
    .clk(clk), .reset(reset), .vif(vif1.master)
  );

  // Reference model: mode 0 idle, 1 run, 2 stopping; p = pixel index in frame
  int k, mode, p, m_fcnt;
  bit m_en, m_ls, m_fs, m_h, m_v;
  bit hq[$];
  bit vq[$];

  function automatic bit h_lvl(int md, int pp);
    int x;
    x = pp % HT;
    return (md != 0 && x >= H_ACTIVE + H_FP &&
            x < H_ACTIVE + H_FP + H_SYNC) ? H_ON : !H_ON;
  endfunction

  function automatic bit v_lvl(int md, int pp);
    int y;
    y = pp / HT;
    return (md != 0 && y >= V_ACTIVE + V_FP &&
            y < V_ACTIVE + V_FP + V_SYNC) ? V_ON : !V_ON;
  endfunction

  function automatic int mx();
    return p % HT;
  endfunction

  function automatic int my();
    return p / HT;
  endfunction

  function automatic bit mblank();
    return mode == 0 || mx() >= H_ACTIVE || my() >= V_ACTIVE;
  endfunction

  task automatic model_step();
    bit hr, vr;
    if (reset) begin
      k = 0; mode = 0; p = 0; m_fcnt = 0;
      m_en = 0; m_ls = 0; m_fs = 0;
      m_h = !H_ON; m_v = !V_ON;
      hq.delete(); vq.delete();
      repeat (SYNC_DELAY) begin
        hq.push_back(!H_ON);
        vq.push_back(!V_ON);
      end
    end else begin
      hr = h_lvl(mode, p);
      vr = v_lvl(mode, p);
      m_ls = 0; m_fs = 0;
      if (m_en) begin
        if (mode == 0) begin
          if (vif.run) mode = 1;
        end else begin
          p = (p + 1) % (HT * VT);
          if (mode == 1 && !vif.run) mode = 2;
          else if (mode == 2 && vif.run) mode = 1;
          else if (mode == 2 && p == 0) mode = 0;
        end
        m_ls = (mode != 0) && (p % HT == 0);
        m_fs = (mode != 0) && (p == 0);
        if (m_fs) m_fcnt = (m_fcnt + 1) & 16'hFFFF;
      end
      k++;
      m_en = (k % CLK_DIV) == CLK_DIV - 1;
      hq.push_back(hr); void'(hq.pop_front()); m_h = hq[0];
      vq.push_back(vr); void'(vq.pop_front()); m_v = vq[0];
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 9;
    if (vif.x_pos !== '0) begin n_bad++; $display("FAIL rst_x got %0d exp 0", vif.x_pos); end
    if (vif.y_pos !== '0) begin n_bad++; $display("FAIL rst_y got %0d exp 0", vif.y_pos); end
    if (vif.blank !== 1'b1) begin n_bad++; $display("FAIL rst_blank got %b exp 1", vif.blank); end
    if (vif.en_pix !== 1'b0) begin n_bad++; $display("FAIL rst_en got %b exp 0", vif.en_pix); end
    if (vif.active !== 1'b0) begin n_bad++; $display("FAIL rst_active got %b exp 0", vif.active); end
    if (vif.h_sync !== !H_ON) begin n_bad++; $display("FAIL rst_h got %b exp %b", vif.h_sync, !H_ON); end
    if (vif.v_sync !== !V_ON) begin n_bad++; $display("FAIL rst_v got %b exp %b", vif.v_sync, !V_ON); end
    if (vif.line_start !== 1'b0) begin n_bad++; $display("FAIL rst_ls got %b exp 0", vif.line_start); end
    if (vif.frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs got %b exp 0", vif.frame_start); end
    reset = 1'b0;
  endtask

  task automatic test_div1();
    int xe, ye, pe;
    bit he;
    for (int m = 1; m <= 40; m++) begin
      @(negedge clk);
      pe = (m >= 2) ? (m - 2) % (HT * VT) : 0;
      xe = pe % HT;
      ye = pe / HT;
      he = h_lvl((m >= 2) ? 1 : 0, pe);
      n_cmp += 5;
      if (vif1.en_pix !== 1'b1) begin n_bad++; $display("FAIL div1_en m=%0d got %b exp 1", m, vif1.en_pix); end
      if (vif1.x_pos !== CW'(xe)) begin n_bad++; $display("FAIL div1_x m=%0d got %0d exp %0d", m, vif1.x_pos, xe); end
      if (vif1.y_pos !== CW'(ye)) begin n_bad++; $display("FAIL div1_y m=%0d got %0d exp %0d", m, vif1.y_pos, ye); end
      if (vif1.h_sync !== he) begin n_bad++; $display("FAIL div1_h m=%0d got %b exp %b", m, vif1.h_sync, he); end
      if (vif.active !== (mode != 0)) begin n_bad++; $display("FAIL idle_active got %b exp 0", vif.active); end
    end
  endtask

  task automatic test_divider();
    int hi;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (vif.en_pix !== m_en) begin n_bad++; $display("FAIL div_en got %b exp %b", vif.en_pix, m_en); end
      hi += int'(vif.en_pix);
    end
    n_cmp++;
    if (hi != 40 / CLK_DIV) begin n_bad++; $display("FAIL div_count got %0d exp %0d", hi, 40 / CLK_DIV); end
  endtask

  task automatic test_line_timing();
    int hcnt;
    hcnt = 0;
    vif.run = 1'b1;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      @(negedge clk);
      n_cmp += 5;
      if (vif.x_pos !== CW'(mx())) begin n_bad++; $display("FAIL line_x got %0d exp %0d", vif.x_pos, mx()); end
      if (vif.y_pos !== CW'(my())) begin n_bad++; $display("FAIL line_y got %0d exp %0d", vif.y_pos, my()); end
      if (vif.blank !== mblank()) begin n_bad++; $display("FAIL line_blank x=%0d got %b exp %b", mx(), vif.blank, mblank()); end
      if (vif.line_start !== m_ls) begin n_bad++; $display("FAIL line_ls got %b exp %b", vif.line_start, m_ls); end
      if (vif.h_sync !== m_h) begin n_bad++; $display("FAIL line_h got %b exp %b", vif.h_sync, m_h); end
      if (i >= FRAME_CLKS - LINE_CLKS && vif.h_sync === H_ON) hcnt++;
    end
    n_cmp++;
    if (hcnt != H_SYNC * CLK_DIV) begin n_bad++; $display("FAIL h_width got %0d exp %0d", hcnt, H_SYNC * CLK_DIV); end
  endtask

  task automatic test_frame_timing();
    int vcnt, last;
    vcnt = 0; last = -1;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      n_cmp += 4;
      if (vif.y_pos !== CW'(my())) begin n_bad++; $display("FAIL frame_y got %0d exp %0d", vif.y_pos, my()); end
      if (vif.v_sync !== m_v) begin n_bad++; $display("FAIL frame_v got %b exp %b", vif.v_sync, m_v); end
      if (vif.frame_start !== m_fs) begin n_bad++; $display("FAIL frame_fs got %b exp %b", vif.frame_start, m_fs); end
      if (vif.active !== 1'b1) begin n_bad++; $display("FAIL frame_active got %b exp 1", vif.active); end
      if (vif.frame_start === 1'b1) begin
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != FRAME_CLKS) begin n_bad++; $display("FAIL fs_period got %0d exp %0d", cyc - last, FRAME_CLKS); end
        end
        last = cyc;
      end
      if (i >= FRAME_CLKS && vif.v_sync === V_ON) vcnt++;
    end
    n_cmp++;
    if (vcnt != V_SYNC * LINE_CLKS) begin n_bad++; $display("FAIL v_width got %0d exp %0d", vcnt, V_SYNC * LINE_CLKS); end
  endtask

  task automatic test_stop();
    bit got;
    for (int i = 0; i < 2 * FRAME_CLKS && !(mode == 1 && my() == 3); i++)
      @(negedge clk);
    vif.run = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !(mode == 0); i++) begin
      @(negedge clk);
      n_cmp += 5;
      if (vif.active !== (mode != 0)) begin n_bad++; $display("FAIL stop_active got %b exp %b", vif.active, mode != 0); end
      if (vif.x_pos !== CW'(mx())) begin n_bad++; $display("FAIL stop_x got %0d exp %0d", vif.x_pos, mx()); end
      if (vif.y_pos !== CW'(my())) begin n_bad++; $display("FAIL stop_y got %0d exp %0d", vif.y_pos, my()); end
      if (vif.blank !== mblank()) begin n_bad++; $display("FAIL stop_blank got %b exp %b", vif.blank, mblank()); end
      if (vif.frame_start !== m_fs) begin n_bad++; $display("FAIL stop_fs got %b exp %b", vif.frame_start, m_fs); end
    end
    n_cmp++;
    if (mode != 0) begin n_bad++; $display("FAIL stop_timeout got mode %0d exp 0", mode); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (vif.frame_start !== 1'b0) begin n_bad++; $display("FAIL idle_fs got %b exp 0", vif.frame_start); end
      if (vif.active !== 1'b0) begin n_bad++; $display("FAIL idle_active got %b exp 0", vif.active); end
    end
    vif.run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 * CLK_DIV + 2 && !got; i++) begin
      @(negedge clk);
      n_cmp++;
      if (vif.frame_start !== m_fs) begin n_bad++; $display("FAIL restart_fs got %b exp %b", vif.frame_start, m_fs); end
      got = (vif.frame_start === 1'b1);
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL restart_timeout got 0 exp 1"); end
  endtask

  task automatic test_restart();
    int t0;
    bit got;
    got = 1'b0;
    for (int i = 0; i < FRAME_CLKS + 10 && !got; i++) begin
      @(negedge clk);
      got = (vif.frame_start === 1'b1);
    end
    t0 = cyc;
    repeat ($urandom_range(10, 100)) @(negedge clk);
    vif.run = 1'b0;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    n_cmp++;
    if (vif.active !== 1'b1) begin n_bad++; $display("FAIL dip_active got %b exp 1", vif.active); end
    vif.run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !got; i++) begin
      @(negedge clk);
      got = (vif.frame_start === 1'b1);
    end
    n_cmp++;
    if (!got || cyc - t0 != FRAME_CLKS) begin
      n_bad++;
      $display("FAIL dip_period got %0d exp %0d", got ? cyc - t0 : -1, FRAME_CLKS);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2 * FRAME_CLKS && !(mode != 0 && my() >= 2); i++)
      @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp += 8;
    if (vif.x_pos !== '0) begin n_bad++; $display("FAIL mid_x got %0d exp 0", vif.x_pos); end
    if (vif.y_pos !== '0) begin n_bad++; $display("FAIL mid_y got %0d exp 0", vif.y_pos); end
    if (vif.blank !== 1'b1) begin n_bad++; $display("FAIL mid_blank got %b exp 1", vif.blank); end
    if (vif.h_sync !== !H_ON) begin n_bad++; $display("FAIL mid_h got %b exp %b", vif.h_sync, !H_ON); end
    if (vif.v_sync !== !V_ON) begin n_bad++; $display("FAIL mid_v got %b exp %b", vif.v_sync, !V_ON); end
    if (vif.en_pix !== 1'b0) begin n_bad++; $display("FAIL mid_en got %b exp 0", vif.en_pix); end
    if (vif.active !== 1'b0) begin n_bad++; $display("FAIL mid_active got %b exp 0", vif.active); end
    if (vif1.x_pos !== '0) begin n_bad++; $display("FAIL mid_x1 got %0d exp 0", vif1.x_pos); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    vif.run = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      n_cmp += 9;
      if (vif.en_pix !== m_en) begin n_bad++; $display("FAIL rnd_en got %b exp %b", vif.en_pix, m_en); end
      if (vif.x_pos !== CW'(mx())) begin n_bad++; $display("FAIL rnd_x got %0d exp %0d", vif.x_pos, mx()); end
      if (vif.y_pos !== CW'(my())) begin n_bad++; $display("FAIL rnd_y got %0d exp %0d", vif.y_pos, my()); end
      if (vif.blank !== mblank()) begin n_bad++; $display("FAIL rnd_blank got %b exp %b", vif.blank, mblank()); end
      if (vif.line_start !== m_ls) begin n_bad++; $display("FAIL rnd_ls got %b exp %b", vif.line_start, m_ls); end
      if (vif.frame_start !== m_fs) begin n_bad++; $display("FAIL rnd_fs got %b exp %b", vif.frame_start, m_fs); end
      if (vif.h_sync !== m_h) begin n_bad++; $display("FAIL rnd_h got %b exp %b", vif.h_sync, m_h); end
      if (vif.v_sync !== m_v) begin n_bad++; $display("FAIL rnd_v got %b exp %b", vif.v_sync, m_v); end
      if (vif.active !== (mode != 0)) begin n_bad++; $display("FAIL rnd_active got %b exp %b", vif.active, mode != 0); end
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      n_cmp++;
      if (vif.frame_cnt !== 16'(m_fcnt)) begin n_bad++; $display("FAIL rnd_fcnt got %0d exp %0d", vif.frame_cnt, m_fcnt); end
`endif
      if (vif.run && $urandom_range(0, 999) < 5) vif.run = 1'b0;
      else if (!vif.run && $urandom_range(0, 999) < 3) vif.run = 1'b1;
    end
  endtask

  initial begin
    vif.run  = 1'b0;
    vif1.run = 1'b1;
    test_reset();
    test_div1();
    test_divider();
    test_line_timing();
    test_frame_timing();
    test_stop();
    test_restart();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised successor to the fixed 640x480 sync_mod + 13-cycle sync delay pair used by the gpu top level.
- Generates a pixel clock-enable from the system clock.
- Runs horizontal/vertical counters for any VESA-style timing.
- Drives blank, line/frame start pulses and sync outputs pre-delayed to match the downstream pixel pipeline.
- Adds a run/stop FSM so software can halt scan-out cleanly at a frame boundary.

Parameters:
- CLK_DIV, 4: system clocks per pixel (>=1); 1 gives en_pix constantly high.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: horizontal sync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vertical sync width, lines.
- V_BP, 33: vertical back porch, lines.
- H_POL, 0: h_sync active level (0 = active-low).
- V_POL, 0: v_sync active level.
- SYNC_DELAY, 13: clk cycles of delay on h_sync/v_sync (0 = no delay).
- CW, 10: width of x_pos/y_pos; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- run, input, 1: level request to scan out.
- en_pix, output, 1: one-clk pixel enable pulse.
- x_pos, output, CW: current horizontal pixel.
- y_pos, output, CW: current line.
- blank, output, 1: 1 outside the active area or when not scanning.
- line_start, output, 1: pulse at x=0 of every line.
- frame_start, output, 1: pulse at x=0, y=0.
- h_sync, output, 1: delayed horizontal sync.
- v_sync, output, 1: delayed vertical sync.
- active, output, 1: FSM not in IDLE.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 continuously from reset.
  - en_pix is registered, high for exactly one clk when div_cnt == CLK_DIV-1; period is CLK_DIV clks.
- Reset values: div_cnt=0, en_pix=0, x_pos=0, y_pos=0, blank=1, line_start=0, frame_start=0, active=0, h_sync=!H_POL, v_sync=!V_POL. The whole delay line is filled with inactive levels.
- FSM states, all transitions taken only on clk edges with en_pix=1:
  - IDLE: counters held at 0, raw syncs inactive, blank=1. Goes to RUN when run=1; that en_pix does not advance the counters, so the first advancing edge starts from x=0, y=0.
  - RUN: counters advance every en_pix. If run=0 sampled, goes to STOPPING.
  - STOPPING: counters keep advancing. Goes to IDLE on the edge where x wraps H_TOTAL-1 -> 0 and y wraps V_TOTAL-1 -> 0, i.e. the current frame always completes. If run returns to 1 while in STOPPING, goes back to RUN with no counter disturbance.
- Counters:
  - x increments per en_pix; at H_TOTAL-1 it wraps to 0 and y increments.
  - y at V_TOTAL-1 wraps to 0 together with x.
  - No intermediate overflow; all compares are on CW-bit unsigned values.
- blank (combinational from registered state/counters):
  - 1 if IDLE, or x >= H_ACTIVE, or y >= V_ACTIVE; 0 otherwise.
  - Changes in the same clk as x_pos/y_pos (undelayed).
- Raw syncs:
  - h_raw active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - v_raw active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. The v window is line-based, so it changes at the x wrap.
  - Both forced inactive in IDLE.
- Delayed syncs:
  - h_sync/v_sync equal the raw syncs shifted through a SYNC_DELAY-stage clk shift register; the register is clocked every clk, not gated by en_pix.
  - SYNC_DELAY=0 means direct combinational assignment.
- line_start/frame_start:
  - Registered one-clk pulses, asserted in the clk after the en_pix edge that produced x=0 (and y=0 for frame_start) while not IDLE.
  - Only the first frame after leaving IDLE gets a frame_start on entry.
- active = (state != IDLE).
- Reset asserted mid-frame: immediate return to the reset values above, regardless of clk.

Optional Feature:
- Macro: VIDEO_TIMING_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt, 16 bits, reset 0.
  - Increments by 1 (mod 2^16) on every frame_start pulse.
  - Holds its value through IDLE; cleared only by reset.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset mid-RUN, sample within the same clk -> x_pos=0, y_pos=0, blank=1, h_sync=1, v_sync=1, en_pix=0, active=0.
- Divider: CLK_DIV=4, run=1 -> en_pix high exactly 1 clk in every 4; with CLK_DIV=1 en_pix is constant 1 after reset release.
- Line timing (defaults):
  - x_pos 639 -> blank 0; x_pos 640 -> blank 1.
  - raw h_sync low for x = 656..751 (96 pixels = 384 clks).
  - h_sync pin falls exactly 13 clks after x_pos becomes 656.
  - x 799 -> 0 increments y.
- Frame timing: v_sync low for y = 490..491 only; frame_start pulses once every 800*525*4 = 1,680,000 clks; y 524 -> 0.
- Stop: drop run at y=100 -> scan continues to x=799, y=524, then active=0, x=y=0, blank=1, no further frame_start. Raise run again -> frame_start one en_pix later. Raise run during STOPPING -> no gap in frame_start period.
- With VIDEO_TIMING_FRAME_CNT_EN: run 3 frames, stop, run 2 more -> frame_cnt=5. Force frame_cnt to 0xFFFF -> next frame_start gives 0x0000.
